// File: rtl/sysid_check_pkg.sv
// ---------------------------------------------------------------------------
// sysid_check_pkg
//   Shared definitions for the system-ID check master and its read unit.
//   Holds the state encodings of the sequencing FSM and of the single-read
//   FSM, the word-select addresses of the sysid responder and a helper that
//   sizes counters from their largest value.
// ---------------------------------------------------------------------------
package sysid_check_pkg;

    // Top-level sequencing states. TOP_READ covers the ISSUE, LAT and GAP
    // phases, which the read unit tracks in detail.
    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_READ,
        TOP_COMPARE,
        TOP_DONE
    } topState_t;

    // States of a single Avalon read transaction.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ISSUE,
        RD_LAT,
        RD_GAP
    } rdState_t;

    // Word addresses inside the sysid control slave.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Number of bits needed to hold values 0..maxVal (at least one bit).
    function automatic int cntWidth(input int maxVal);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) > maxVal) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/sysid_avm_read_unit.sv
// ---------------------------------------------------------------------------
// sysid_avm_read_unit
//   Performs one Avalon-MM read at a time: holds read/address until the
//   responder drops waitrequest, waits out a fixed read latency, and re-issues
//   the read after a one-cycle gap when waitrequest stays high for too long.
//   A new read can be chained in the cycle the previous one completes, so two
//   zero-latency reads go out back to back.
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   go, addr          start a read of word 'addr' (sampled when idle or on
//                     the completion cycle of the current read)
//   avm_address       Avalon word address (stable for the whole attempt)
//   avm_read          Avalon read request
//   avm_waitrequest   Avalon stall
//   avm_readdata      Avalon read data
//   rd_done           read data valid on rd_data this cycle
//   rd_data           read data (pass-through, only meaningful with rd_done)
//   rd_timeout        the read failed after all retries (one-cycle pulse)
// ---------------------------------------------------------------------------
module sysid_avm_read_unit
    import sysid_check_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        addr,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        rd_timeout
);

    localparam int TO_W = cntWidth(TIMEOUT_CYCLES);
    localparam int RT_W = cntWidth(MAX_RETRIES);
    localparam int LT_W = cntWidth(READ_LATENCY);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    rdState_t        r_state;
    rdState_t        w_nextState;
    logic            r_addr;
    logic [TO_W-1:0] r_toCnt;
    logic [RT_W-1:0] r_retries;
    logic [LT_W-1:0] r_latCnt;

    logic w_accept;
    logic w_toExpire;
    logic w_canRetry;
    logic w_latLast;
    logic w_load;

    // An accept is the standard Avalon handshake; the timeout fires on the
    // last allowed stalled cycle of an attempt, so an attempt is exactly
    // TIMEOUT_CYCLES cycles of read-high-and-stalled.
    assign w_accept   = (r_state == RD_ISSUE) && !avm_waitrequest;
    assign w_toExpire = (r_state == RD_ISSUE) && avm_waitrequest && (r_toCnt == TO_LAST);
    assign w_canRetry = (r_retries < RT_MAX);
    assign w_latLast  = (r_state == RD_LAT) && (r_latCnt == LT_LAST);

    // Data is valid on the accept cycle for zero latency, otherwise on the
    // final latency cycle.
    assign rd_done    = (READ_LATENCY == 0) ? w_accept : w_latLast;
    assign rd_data    = avm_readdata;
    assign rd_timeout = w_toExpire && !w_canRetry;

    // A new word is latched when idle or on the cycle the current read
    // completes; this is also where the per-word retry count restarts.
    assign w_load = go && ((r_state == RD_IDLE) || rd_done);

    assign avm_read    = (r_state == RD_ISSUE);
    assign avm_address = r_addr;

    // State register of the read transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: chain straight into another ISSUE when a new read is
    // requested on completion, otherwise fall back to idle. A timeout with
    // retries left inserts a single idle GAP cycle before re-issuing.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RD_IDLE: begin
                if (go) begin
                    w_nextState = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (w_accept) begin
                    if (READ_LATENCY != 0) begin
                        w_nextState = RD_LAT;
                    end else if (go) begin
                        w_nextState = RD_ISSUE;
                    end else begin
                        w_nextState = RD_IDLE;
                    end
                end else if (w_toExpire) begin
                    w_nextState = w_canRetry ? RD_GAP : RD_IDLE;
                end
            end
            RD_LAT: begin
                if (w_latLast) begin
                    w_nextState = go ? RD_ISSUE : RD_IDLE;
                end
            end
            RD_GAP: begin
                w_nextState = RD_ISSUE;
            end
            default: begin
                w_nextState = RD_IDLE;
            end
        endcase
    end

    // Address, stall counter, retry counter and latency counter. The stall
    // counter only runs while a request is actually outstanding and restarts
    // on every accept or expired attempt.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr    <= ADDR_ID;
            r_toCnt   <= '0;
            r_retries <= '0;
            r_latCnt  <= '0;
        end else begin
            if (w_load) begin
                r_addr <= addr;
            end

            if (w_load || w_accept || w_toExpire) begin
                r_toCnt <= '0;
            end else if ((r_state == RD_ISSUE) && avm_waitrequest) begin
                r_toCnt <= r_toCnt + TO_W'(1);
            end

            if (w_load) begin
                r_retries <= '0;
            end else if (w_toExpire && w_canRetry) begin
                r_retries <= r_retries + RT_W'(1);
            end

            if (w_accept) begin
                r_latCnt <= '0;
            end else if (r_state == RD_LAT) begin
                r_latCnt <= r_latCnt + LT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sysid_check_master.sv
// ---------------------------------------------------------------------------
// sysid_check_master
//   Boot-time health check of a sysid responder: reads the ID word and the
//   timestamp word over Avalon-MM, compares them with the values this build
//   expects and reports pass/fail together with the words it captured.
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start                launch a check from IDLE or DONE
//   avm_address          0 = ID word, 1 = timestamp word
//   avm_read             Avalon read request
//   avm_waitrequest      Avalon stall
//   avm_readdata         Avalon read data
//   busy                 check in progress
//   done                 check finished (level, cleared on the next launch)
//   pass                 overall result, valid with done
//   id_mismatch          captured ID differs from EXPECTED_ID
//   ts_mismatch          captured timestamp differs from EXPECTED_TIMESTAMP
//   timeout              a read ran out of retries
//   captured_id          last ID word read
//   captured_ts          last timestamp word read
// ---------------------------------------------------------------------------
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1512003615,
    parameter int          CHECK_TIMESTAMP    = 1,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 16,
    parameter int          MAX_RETRIES        = 2,
    parameter int          AUTO_START         = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    topState_t   r_state;
    topState_t   w_nextState;
    logic        r_sel;
    logic        r_autoPending;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_idMis;
    logic        r_tsMis;
    logic        r_timeout;
    logic [31:0] r_capId;
    logic [31:0] r_capTs;

    logic        w_launch;
    logic        w_goRead;
    logic        w_rdAddr;
    logic        w_rdDone;
    logic [31:0] w_rdData;
    logic        w_rdTimeout;
    logic        w_idMis;
    logic        w_tsMis;

    // A launch is accepted only when not busy. The auto-start request is
    // armed by reset, so each reset release produces exactly one check.
    assign w_launch = ((r_state == TOP_IDLE) || (r_state == TOP_DONE)) && (start || r_autoPending);

    // The ID read starts with the launch; the timestamp read is chained onto
    // the completion of the ID read so no idle cycle appears between them.
    assign w_goRead = w_launch || ((r_state == TOP_READ) && w_rdDone && (r_sel == ADDR_ID));
    assign w_rdAddr = (r_state == TOP_READ) ? ADDR_TS : ADDR_ID;

    assign w_idMis = (r_capId != EXPECTED_ID);
    assign w_tsMis = (r_capTs != EXPECTED_TIMESTAMP);

    sysid_avm_read_unit #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_readUnit (
        .clock           (clock),
        .reset           (reset),
        .go              (w_goRead),
        .addr            (w_rdAddr),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .rd_done         (w_rdDone),
        .rd_data         (w_rdData),
        .rd_timeout      (w_rdTimeout)
    );

    // State register of the check sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= TOP_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Sequencing: read both words, spend one cycle comparing, then park in
    // DONE until relaunched. A failed read skips the compare cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            TOP_IDLE, TOP_DONE: begin
                if (w_launch) begin
                    w_nextState = TOP_READ;
                end
            end
            TOP_READ: begin
                if (w_rdTimeout) begin
                    w_nextState = TOP_DONE;
                end else if (w_rdDone && (r_sel == ADDR_TS)) begin
                    w_nextState = TOP_COMPARE;
                end
            end
            TOP_COMPARE: begin
                w_nextState = TOP_DONE;
            end
            default: begin
                w_nextState = TOP_IDLE;
            end
        endcase
    end

    // Result and capture registers. Captured words only change on a
    // completed read, so a word that never arrives keeps its previous value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel         <= ADDR_ID;
            r_autoPending <= (AUTO_START != 0);
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_idMis       <= 1'b0;
            r_tsMis       <= 1'b0;
            r_timeout     <= 1'b0;
            r_capId       <= '0;
            r_capTs       <= '0;
        end else begin
            if (w_launch) begin
                r_sel         <= ADDR_ID;
                r_autoPending <= 1'b0;
                r_busy        <= 1'b1;
                r_done        <= 1'b0;
                r_pass        <= 1'b0;
                r_idMis       <= 1'b0;
                r_tsMis       <= 1'b0;
                r_timeout     <= 1'b0;
            end else if (r_state == TOP_READ) begin
                if (w_rdDone) begin
                    if (r_sel == ADDR_ID) begin
                        r_capId <= w_rdData;
                        r_sel   <= ADDR_TS;
                    end else begin
                        r_capTs <= w_rdData;
                    end
                end else if (w_rdTimeout) begin
                    r_timeout <= 1'b1;
                    r_idMis   <= w_idMis;
                    r_tsMis   <= w_tsMis;
                    r_pass    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
            end else if (r_state == TOP_COMPARE) begin
                r_idMis <= w_idMis;
                r_tsMis <= w_tsMis;
                r_pass  <= !w_idMis && !((CHECK_TIMESTAMP != 0) && w_tsMis) && !r_timeout;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_mismatch = r_idMis;
    assign ts_mismatch = r_tsMis;
    assign timeout     = r_timeout;
    assign captured_id = r_capId;
    assign captured_ts = r_capTs;

endmodule
